hamming_secded_syndrome_stage: RTL
==================================

Name: hamming_secded_syndrome_stage

Overview:
Registered front-end of the SECDED (8,4) receive path. It accepts raw received codewords on a valid/ready handshake, computes the 3-bit syndrome and the overall-parity flag, classifies the error, and presents {cw, syn, ov} to hamming_secded_corrector one cycle later. A 2-entry skid buffer provides full throughput under backpressure. Saturating single- and double-error counters give link-quality statistics.

Parameters:
CNT_W, 16, width of each error counter (min 1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  upstream codeword valid
s_ready  out  1  stage can accept a codeword
s_cw  in  8  received codeword, layout below
m_valid  out  1  output word valid
m_ready  in  1  corrector side ready
m_cw  out  8  codeword passed through unmodified
m_syn  out  3  syndrome {s3,s2,s1}
m_ov  out  1  overall parity mismatch
m_err  out  2  error class (err_class_e)
cnt_clr  in  1  synchronous clear of both counters
cnt_single  out  CNT_W  count of single-bit (corrected) words, saturating
cnt_double  out  CNT_W  count of double-bit (uncorrectable) words, saturating

Behaviour:
- Codeword bit map (Hamming position in parentheses): cw[0]=p0 (overall), cw[2]=p1 (1), cw[1]=p2 (2), cw[3]=d0 (3), cw[4]=p3 (4), cw[5]=d1 (5), cw[6]=d2 (6), cw[7]=d3 (7).
- s1 = cw[2]^cw[3]^cw[5]^cw[7]
- s2 = cw[1]^cw[3]^cw[6]^cw[7]
- s3 = cw[4]^cw[5]^cw[6]^cw[7]
- ov = XOR of all 8 bits (even parity).
- Classification:
  - syn=0, ov=0 → ERR_NONE (0).
  - ov=1 → ERR_SINGLE (1); syn=0 with ov=1 means p0 itself flipped.
  - syn≠0, ov=0 → ERR_DOUBLE (2).
  - Code 3 is never produced.
- Handshake:
  - Input is accepted on s_valid&&s_ready.
  - Output transfers on m_valid&&m_ready.
  - m_* must hold stable while m_valid=1 and m_ready=0.
- Latency: one cycle from acceptance to m_valid=1 when the buffer is empty.
- Skid buffer, 2 entries (main + skid). States:
  - EMPTY: m_valid=0, s_ready=1.
    - Accept → ONE.
  - ONE: m_valid=1, s_ready=1.
    - Accept with no transfer → TWO (new word to skid).
    - Accept with transfer → ONE (new word to main).
    - Transfer only → EMPTY.
  - TWO: m_valid=1, s_ready=0.
    - Transfer → ONE (skid moves to main).
- s_ready is a registered function of state, with no combinational path from m_ready.
- Ordering is strictly FIFO; no word is dropped or duplicated.
- Syndrome, ov and class are computed at input acceptance and stored alongside cw.
- Counters:
  - Update on output transfer only: ERR_SINGLE increments cnt_single, ERR_DOUBLE increments cnt_double.
  - Both saturate at 2^CNT_W−1.
  - cnt_clr has priority over a same-cycle increment; result is 0.
- Reset (rst_n low, any time, including mid-transfer):
  - State → EMPTY; all buffered words are discarded.
  - m_valid=0, m_cw=0, m_syn=0, m_ov=0, m_err=0, counters=0.
  - s_ready=0 while rst_n is low; s_ready=1 from the first clock after release.

Decomposition:
- hamming_pkg holds:
  - err_class_e (ERR_NONE=0, ERR_SINGLE=1, ERR_DOUBLE=2).
  - Bit-index localparams for p0..p3 and d0..d3.
  - Function calc_syn(cw) returning {s3,s2,s1}.
- Sub-module hamming_secded_syn_calc: combinational cw → {syn, ov, err}. It is instantiated once at the input, and the corrector bench reuses it as its reference model.

Test Plan:
- Reset then clean codeword s_cw=8'h00 with m_ready=1 → next cycle m_valid=1, m_syn=0, m_ov=0, m_err=0, counters unchanged.
- Single flip: valid word with cw[5] (d1, position 5) inverted, m_ready=1 → m_syn=3'd5, m_ov=1, m_err=1, cnt_single=1. Then cw[0] inverted → syn=0, ov=1, err=1, cnt_single=2.
- Double flip: cw[3] and cw[6] inverted → syn=3'd5, ov=0, err=2, cnt_double=1.
- Backpressure: stream 4 words back-to-back while m_ready=0 for 3 cycles → s_ready drops after 2 accepts, m_* stable throughout; release m_ready → all 4 words arrive in order, no gaps after release.
- Saturation and clear with CNT_W=2: 5 single-error transfers → cnt_single=3. Assert cnt_clr in the same cycle as a 6th transfer → cnt_single=0.
- Async reset in state TWO: pull rst_n low between clock edges → m_valid=0 immediately, counters=0. After release, the first new word emerges with 1-cycle latency and no stale data.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the SECDED (8,4) receive path: error classes,
// codeword bit positions, the buffered word record and parity helpers.
package hamming_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_SINGLE = 2'd1,
        ERR_DOUBLE = 2'd2
    } err_class_e;

    // Physical bit index of each Hamming position inside the 8-bit codeword
    localparam int unsigned P0_IDX = 0;   // overall parity
    localparam int unsigned P1_IDX = 2;   // position 1
    localparam int unsigned P2_IDX = 1;   // position 2
    localparam int unsigned D0_IDX = 3;   // position 3
    localparam int unsigned P3_IDX = 4;   // position 4
    localparam int unsigned D1_IDX = 5;   // position 5
    localparam int unsigned D2_IDX = 6;   // position 6
    localparam int unsigned D3_IDX = 7;   // position 7

    // One buffered entry: raw codeword plus its decode information
    typedef struct packed {
        logic [7:0] cw;
        logic [2:0] syn;
        logic       ov;
        err_class_e err;
    } syn_word_t;

    // Syndrome {s3,s2,s1}; a non-zero value names the flipped Hamming position
    function automatic logic [2:0] calc_syn(input logic [7:0] cw);
        logic s1;
        logic s2;
        logic s3;
        s1 = cw[P1_IDX] ^ cw[D0_IDX] ^ cw[D1_IDX] ^ cw[D3_IDX];
        s2 = cw[P2_IDX] ^ cw[D0_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
        s3 = cw[P3_IDX] ^ cw[D1_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
        return {s3, s2, s1};
    endfunction

    // Even parity over the whole codeword; 1 means an odd number of flips
    function automatic logic calc_ov(input logic [7:0] cw);
        return cw[P0_IDX] ^ cw[P1_IDX] ^ cw[P2_IDX] ^ cw[D0_IDX] ^
               cw[P3_IDX] ^ cw[D1_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
    endfunction

endpackage

// File: rtl/hamming_secded_syn_calc.sv
// Combinational syndrome / overall-parity / error-class decode of one codeword.
module hamming_secded_syn_calc
    import hamming_pkg::*;
(
    input  logic [7:0] i_cw,
    output logic [2:0] o_syn,
    output logic       o_ov,
    output err_class_e o_err
);

    assign o_syn = calc_syn(i_cw);
    assign o_ov  = calc_ov(i_cw);

    // Odd flip count is correctable; even non-zero syndrome is not
    always_comb begin
        o_err = ERR_NONE;
        if (o_ov) begin
            o_err = ERR_SINGLE;
        end else if (o_syn != 3'd0) begin
            o_err = ERR_DOUBLE;
        end else begin
            o_err = ERR_NONE;
        end
    end

endmodule

// File: rtl/hamming_secded_syndrome_stage.sv
// Registered syndrome stage: decodes words on acceptance, holds them in a
// 2-entry skid buffer (main + skid) and counts error classes on transfer.
module hamming_secded_syndrome_stage
    import hamming_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_cw,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_cw,
    output logic [2:0]       m_syn,
    output logic             m_ov,
    output logic [1:0]       m_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_double
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           r_state;
    syn_word_t        r_main;
    syn_word_t        r_skid;
    logic             r_s_ready;
    logic             r_m_valid;
    logic [CNT_W-1:0] r_cnt_single;
    logic [CNT_W-1:0] r_cnt_double;

    logic [2:0]       w_syn;
    logic             w_ov;
    err_class_e       w_err;
    syn_word_t        w_in;
    logic             w_acc;
    logic             w_xfer;

    hamming_secded_syn_calc u_syn_calc (
        .i_cw  (s_cw),
        .o_syn (w_syn),
        .o_ov  (w_ov),
        .o_err (w_err)
    );

    assign w_in   = '{cw: s_cw, syn: w_syn, ov: w_ov, err: w_err};
    assign w_acc  = s_valid && r_s_ready;
    assign w_xfer = r_m_valid && m_ready;

    // Skid-buffer FSM; main always feeds the outputs, skid catches the word
    // accepted while the consumer stalls, so s_ready never depends on m_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_main    <= '0;
            r_skid    <= '0;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_s_ready <= 1'b1;
                    if (w_acc) begin
                        r_main    <= w_in;
                        r_m_valid <= 1'b1;
                        r_state   <= ST_ONE;
                    end else begin
                        r_m_valid <= 1'b0;
                    end
                end
                ST_ONE: begin
                    if (w_acc && !w_xfer) begin
                        r_skid    <= w_in;
                        r_s_ready <= 1'b0;
                        r_state   <= ST_TWO;
                    end else if (w_acc) begin
                        r_main    <= w_in;
                        r_s_ready <= 1'b1;
                    end else if (w_xfer) begin
                        r_m_valid <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= ST_EMPTY;
                    end else begin
                        r_m_valid <= 1'b1;
                        r_s_ready <= 1'b1;
                    end
                end
                ST_TWO: begin
                    if (w_xfer) begin
                        r_main    <= r_skid;
                        r_s_ready <= 1'b1;
                        r_state   <= ST_ONE;
                    end else begin
                        r_s_ready <= 1'b0;
                    end
                end
                default: begin
                    r_m_valid <= 1'b0;
                    r_s_ready <= 1'b1;
                    r_state   <= ST_EMPTY;
                end
            endcase
        end
    end

    // Link-quality counters: bump on transfer, saturate, clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_single <= '0;
            r_cnt_double <= '0;
        end else if (cnt_clr) begin
            r_cnt_single <= '0;
            r_cnt_double <= '0;
        end else if (w_xfer) begin
            case (r_main.err)
                ERR_SINGLE: begin
                    if (r_cnt_single != CNT_MAX) begin
                        r_cnt_single <= r_cnt_single + CNT_ONE;
                    end
                end
                ERR_DOUBLE: begin
                    if (r_cnt_double != CNT_MAX) begin
                        r_cnt_double <= r_cnt_double + CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s_ready    = r_s_ready;
    assign m_valid    = r_m_valid;
    assign m_cw       = r_main.cw;
    assign m_syn      = r_main.syn;
    assign m_ov       = r_main.ov;
    assign m_err      = r_main.err;
    assign cnt_single = r_cnt_single;
    assign cnt_double = r_cnt_double;

endmodule
